// File: rtl/bcp_pe_chain.sv
// bcp_pe_chain: successor BCP processing element walking a clause list per assigned literal.
// Optional statistics counters are enabled with the BCP_PE_STATS_EN macro.
// GST lit_state_t encoding per 2-bit slot: 0 = UNDEFINED, 1 = FALSE, 2 = TRUE, 3 = neither.
module bcp_pe_chain #(
    parameter int CLA_LEN = 3,
    parameter int LIT_W   = 8,
    parameter int PTR_W   = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LIT_W-1:0]         lit_in,
    input  logic                     lit_in_valid,
    output logic                     lit_in_ready,
    input  logic [PTR_W-1:0]         init_ptr,
    output logic                     node_req,
    output logic [PTR_W-1:0]         node_ptr,
    input  logic                     node_rvalid,
    input  logic [CLA_LEN*LIT_W-1:0] node_lits,
    input  logic [CLA_LEN*PTR_W-1:0] node_ptrs,
    output logic [CLA_LEN*LIT_W-1:0] gst_cla,
    output logic                     gst_cla_valid,
    input  logic [CLA_LEN*2-1:0]     gst_state,
    input  logic                     halt,
    output logic                     imply_valid,
    output logic [LIT_W-1:0]         imply_lit,
    input  logic                     imply_ready,
    output logic                     conflict,
    output logic                     done
`ifdef BCP_PE_STATS_EN
    ,
    output logic [31:0]              stat_nodes,
    output logic [31:0]              stat_implies,
    output logic [31:0]              stat_conflicts
`endif
);
    localparam int NW = $clog2(CLA_LEN + 1);
    localparam logic [1:0] ST_UNDEF = 2'd0;
    localparam logic [1:0] ST_FALSE = 2'd1;
    localparam logic [1:0] ST_TRUE  = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL, S_EMIT} state_t;

    state_t                   state_q, state_d;
    logic [LIT_W-1:0]         cur_lit_q, cur_lit_d, imply_lit_q, imply_lit_d;
    logic [PTR_W-1:0]         cur_ptr_q, cur_ptr_d, next_q, next_d;
    logic [CLA_LEN*LIT_W-1:0] lits_q, lits_d;
    logic [CLA_LEN*PTR_W-1:0] ptrs_q, ptrs_d;
    logic                     sat, found;
    logic [NW-1:0]            nundef;
    logic [LIT_W-1:0]         unit_lit, l;
    logic [1:0]               s;
    logic [PTR_W-1:0]         next;

    assign lit_in_ready  = rst_n && state_q == S_IDLE && !halt;
    assign node_req      = state_q == S_REQ && !halt;
    assign node_ptr      = cur_ptr_q;
    assign gst_cla       = lits_q;
    assign gst_cla_valid = state_q == S_EVAL;
    assign imply_valid   = state_q == S_EMIT;
    assign imply_lit     = imply_lit_q;

    // Clause evaluation against GST and selection of the successor pointer for cur_lit
    always_comb begin
        sat      = 1'b0;
        found    = 1'b0;
        nundef   = '0;
        unit_lit = '0;
        next     = '0;
        l        = '0;
        s        = '0;
        for (int i = 0; i < CLA_LEN; i++) begin
            l = lits_q[i*LIT_W +: LIT_W];
            s = gst_state[2*i +: 2];
            if (l != '0) begin
                if ((s == ST_TRUE && !l[LIT_W-1]) || (s == ST_FALSE && l[LIT_W-1])) sat = 1'b1;
                if (s == ST_UNDEF) begin
                    nundef   = nundef + 1'b1;
                    unit_lit = l;
                end
            end
            if (!found && l == cur_lit_q) begin
                found = 1'b1;
                next  = ptrs_q[i*PTR_W +: PTR_W];
            end
        end
    end

    // Next-state and pulse outputs; halt freezes everything except node capture in WAIT
    always_comb begin
        state_d     = state_q;
        cur_lit_d   = cur_lit_q;
        cur_ptr_d   = cur_ptr_q;
        lits_d      = lits_q;
        ptrs_d      = ptrs_q;
        next_d      = next_q;
        imply_lit_d = imply_lit_q;
        done        = 1'b0;
        conflict    = 1'b0;
        case (state_q)
            S_IDLE: if (lit_in_valid && lit_in_ready) begin
                cur_lit_d = lit_in;
                cur_ptr_d = init_ptr;
                if (init_ptr == '0 || lit_in == '0) done = 1'b1;
                else state_d = S_REQ;
            end
            S_REQ: if (!halt) state_d = S_WAIT;
            S_WAIT: if (node_rvalid) begin
                lits_d  = node_lits;
                ptrs_d  = node_ptrs;
                state_d = S_EVAL;
            end
            S_EVAL: if (!halt) begin
                if (!sat && nundef == NW'(0)) begin
                    conflict = 1'b1;
                    state_d  = S_IDLE;
                end else if (!sat && nundef == NW'(1)) begin
                    imply_lit_d = unit_lit;
                    next_d      = next;
                    state_d     = S_EMIT;
                end else if (next != '0) begin
                    cur_ptr_d = next;
                    state_d   = S_REQ;
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_EMIT: if (imply_ready && !halt) begin
                if (next_q != '0) begin
                    cur_ptr_d = next_q;
                    state_d   = S_REQ;
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_lit_q   <= '0;
            cur_ptr_q   <= '0;
            lits_q      <= '0;
            ptrs_q      <= '0;
            next_q      <= '0;
            imply_lit_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_lit_q   <= cur_lit_d;
            cur_ptr_q   <= cur_ptr_d;
            lits_q      <= lits_d;
            ptrs_q      <= ptrs_d;
            next_q      <= next_d;
            imply_lit_q <= imply_lit_d;
        end
    end

`ifdef BCP_PE_STATS_EN
    logic [31:0] nodes_q, nodes_d, implies_q, implies_d, conflicts_q, conflicts_d;

    // Saturating event counters
    always_comb begin
        nodes_d     = nodes_q + 32'((state_q == S_EVAL && !halt) && ~&nodes_q);
        implies_d   = implies_q + 32'((state_q == S_EMIT && imply_ready && !halt) && ~&implies_q);
        conflicts_d = conflicts_q + 32'(conflict && ~&conflicts_q);
    end

    // Counter registers, cleared by reset only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nodes_q     <= '0;
            implies_q   <= '0;
            conflicts_q <= '0;
        end else begin
            nodes_q     <= nodes_d;
            implies_q   <= implies_d;
            conflicts_q <= conflicts_d;
        end
    end

    assign stat_nodes     = nodes_q;
    assign stat_implies   = implies_q;
    assign stat_conflicts = conflicts_q;
`endif
endmodule

// File: tb/tb_bcp_pe_chain.sv
// tb_bcp_pe_chain: directed self-checking bench with a 1-cycle CLQ responder model.
module tb_bcp_pe_chain;
    localparam logic [1:0] UN = 2'd0, FA = 2'd1, TR = 2'd2;

    logic        clk = 0, rst_n = 0;
    logic [7:0]  lit_in = 0;
    logic        lit_in_valid = 0, lit_in_ready;
    logic [9:0]  init_ptr = 0;
    logic        node_req;
    logic [9:0]  node_ptr;
    logic        node_rvalid = 0;
    logic [23:0] node_lits = 0;
    logic [29:0] node_ptrs = 0;
    logic [23:0] gst_cla;
    logic        gst_cla_valid;
    logic [5:0]  gst_state = 0;
    logic        halt = 0;
    logic        imply_valid;
    logic [7:0]  imply_lit;
    logic        imply_ready = 0;
    logic        conflict, done;
`ifdef BCP_PE_STATS_EN
    logic [31:0] stat_nodes, stat_implies, stat_conflicts;
`endif

    bcp_pe_chain dut (
        .clk(clk), .rst_n(rst_n), .lit_in(lit_in), .lit_in_valid(lit_in_valid),
        .lit_in_ready(lit_in_ready), .init_ptr(init_ptr), .node_req(node_req),
        .node_ptr(node_ptr), .node_rvalid(node_rvalid), .node_lits(node_lits),
        .node_ptrs(node_ptrs), .gst_cla(gst_cla), .gst_cla_valid(gst_cla_valid),
        .gst_state(gst_state), .halt(halt), .imply_valid(imply_valid),
        .imply_lit(imply_lit), .imply_ready(imply_ready), .conflict(conflict), .done(done)
`ifdef BCP_PE_STATS_EN
        , .stat_nodes(stat_nodes), .stat_implies(stat_implies), .stat_conflicts(stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    logic [23:0] mlits [0:15];
    logic [29:0] mptrs [0:15];
    logic        pend = 0, resp_hold = 0;
    logic [9:0]  pptr = 0;
    int checks = 0, errors = 0, nreq = 0, ndone = 0, nconf = 0;
    int b_req, b_done, b_conf;

    always @(posedge clk) begin
        node_rvalid <= 1'b0;
        if ((node_req || pend) && !resp_hold) begin
            node_rvalid <= 1'b1;
            pend        <= 1'b0;
            node_lits   <= mlits[node_req ? node_ptr[3:0] : pptr[3:0]];
            node_ptrs   <= mptrs[node_req ? node_ptr[3:0] : pptr[3:0]];
        end else if (node_req) begin
            pend <= 1'b1;
            pptr <= node_ptr;
        end
    end

    always @(posedge clk) begin
        if (node_req) nreq <= nreq + 1;
        if (done) ndone <= ndone + 1;
        if (conflict) nconf <= nconf + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] l, input logic [9:0] p);
        lit_in = l;
        init_ptr = p;
        lit_in_valid = 1;
        #1;
        chk("start_ready", lit_in_ready, 1);
        tick();
        lit_in_valid = 0;
        #1;
    endtask

    task automatic snap();
        b_req = nreq;
        b_done = ndone;
        b_conf = nconf;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mlits[i] = '0;
            mptrs[i] = '0;
        end
        mlits[5]  = {8'd7, 8'd4, 8'hFD};  mptrs[5]  = {10'd0, 10'd0, 10'd0};
        mlits[6]  = {8'd7, 8'hFC, 8'hFD}; mptrs[6]  = {10'd0, 10'd0, 10'd0};
        mlits[7]  = {8'd0, 8'd5, 8'hFE};  mptrs[7]  = {10'd0, 10'd0, 10'd0};
        mlits[10] = {8'd8, 8'd3, 8'hFD};  mptrs[10] = {10'd0, 10'd9, 10'd9};
        mlits[9]  = {8'd8, 8'd3, 8'hFD};  mptrs[9]  = {10'd0, 10'd0, 10'd0};

        #2;
        chk("rst_ready", lit_in_ready, 0);
        chk("rst_req", node_req, 0);
        chk("rst_imply", {imply_valid, imply_lit}, 0);
        chk("rst_gst", {gst_cla_valid, gst_cla}, 0);
        chk("rst_pulses", {conflict, done}, 0);
        tick();
        rst_n = 1;
        tick();
        chk("idle_ready", lit_in_ready, 1);

        // 1: single node, all undefined, no successor
        snap();
        gst_state = {UN, UN, UN};
        start(8'd3, 10'd5);
        chk("t1_req", node_req, 1);
        chk("t1_ptr", node_ptr, 5);
        tick();
        chk("t1_wait", {node_req, gst_cla_valid}, 0);
        tick();
        chk("t1_eval", gst_cla_valid, 1);
        chk("t1_cla", gst_cla, 24'h0704FD);
        chk("t1_done", {done, conflict, imply_valid}, 3'b100);
        tick();
        chk("t1_idle", lit_in_ready, 1);
        chk("t1_nreq", nreq - b_req, 1);
        chk("t1_ndone", ndone - b_done, 1);

        // 2: unit clause, implication held under back-pressure
        snap();
        gst_state = {UN, TR, TR};
        start(8'd3, 10'd6);
        tick();
        tick();
        chk("t2_eval", {gst_cla_valid, done, conflict}, 3'b100);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t2_hold_v", imply_valid, 1);
            chk("t2_hold_lit", imply_lit, 8'd7);
            chk("t2_hold_done", done, 0);
            tick();
        end
        imply_ready = 1;
        #1;
        chk("t2_acc", {imply_valid, done}, 2'b11);
        tick();
        imply_ready = 0;
        #1;
        chk("t2_after", {imply_valid, lit_in_ready}, 2'b01);
        chk("t2_ndone", ndone - b_done, 1);

        // 3: conflict, padding slot ignored
        snap();
        gst_state = {UN, FA, TR};
        start(8'd2, 10'd7);
        tick();
        tick();
        chk("t3_eval", {conflict, done}, 2'b10);
        tick();
        chk("t3_idle", {lit_in_ready, conflict, imply_valid}, 3'b100);
        chk("t3_nconf", nconf - b_conf, 1);
        chk("t3_nodone", ndone - b_done, 0);
`ifdef BCP_PE_STATS_EN
        chk("stat_nodes", stat_nodes, 3);
        chk("stat_implies", stat_implies, 1);
        chk("stat_conflicts", stat_conflicts, 1);
`endif

        // 4: chain 10 -> 9 -> 0 with halt during the WAIT of node 9
        snap();
        gst_state = {UN, UN, UN};
        start(8'd3, 10'd10);
        tick();
        tick();
        chk("t4_eval1", {gst_cla_valid, done, conflict}, 3'b100);
        tick();
        chk("t4_req2", {node_req, node_ptr}, {1'b1, 10'd9});
        resp_hold = 1;
        tick();
        halt = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_frozen", {node_req, gst_cla_valid, imply_valid, lit_in_ready, done}, 0);
            chk("t4_cla_frozen", gst_cla, 24'h0803FD);
            tick();
        end
        halt = 0;
        resp_hold = 0;
        tick();
        tick();
        chk("t4_eval2", {gst_cla_valid, done}, 2'b11);
        tick();
        chk("t4_nreq", nreq - b_req, 2);
        chk("t4_ndone", ndone - b_done, 1);

        // halt in IDLE blocks acceptance; zero init_ptr gives an immediate done
        lit_in = 8'd5;
        init_ptr = 10'd0;
        lit_in_valid = 1;
        halt = 1;
        #1;
        chk("halt_idle", {lit_in_ready, done}, 0);
        halt = 0;
        #1;
        chk("nullptr_done", {lit_in_ready, done}, 2'b11);
        tick();
        lit_in = 8'd0;
        init_ptr = 10'd5;
        #1;
        chk("zerolit_done", done, 1);
        tick();
        lit_in_valid = 0;
        #1;
        chk("zerolit_nofetch", {node_req, lit_in_ready}, 2'b01);

        // 7: handshake masked under halt in EMIT
        gst_state = {UN, TR, TR};
        start(8'd3, 10'd6);
        tick();
        tick();
        tick();
        halt = 1;
        imply_ready = 1;
        #1;
        chk("t7_masked", {imply_valid, done}, 2'b10);
        tick();
        halt = 0;
        #1;
        chk("t7_acc", {imply_valid, done, imply_lit}, {2'b11, 8'd7});
        tick();
        imply_ready = 0;

        // 5: reset during WAIT, late response discarded
        gst_state = {UN, UN, UN};
        start(8'd3, 10'd5);
        resp_hold = 1;
        tick();
        rst_n = 0;
        #1;
        chk("t5_rst_out", {lit_in_ready, node_req, gst_cla_valid, imply_valid, done, conflict}, 0);
        chk("t5_rst_ptr", node_ptr, 0);
`ifdef BCP_PE_STATS_EN
        chk("t5_rst_stats", {stat_nodes, stat_implies}, 0);
`endif
        tick();
        rst_n = 1;
        resp_hold = 0;
        tick();
        tick();
        chk("t5_ignored", {gst_cla_valid, done, node_req, lit_in_ready}, 4'b0001);
        chk("t5_cla", gst_cla, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
